// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory.
package data_mem_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dm_read_pipe.sv
// RD_LAT-deep read response pipe: valid, data and error move together; data holds when idle.
module dm_read_pipe #(
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              err_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    logic [RD_LAT-1:0] vld_p_q;
    logic [RD_LAT-1:0] err_p_q;
    logic [DATA_W-1:0] data_p_q [RD_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p_q <= '0;
            err_p_q <= '0;
            for (int s = 0; s < RD_LAT; s++) data_p_q[s] <= '0;
        end else begin
            vld_p_q[0] <= vld_i;
            err_p_q[0] <= vld_i & err_i;
            if (vld_i) data_p_q[0] <= data_i;
            // Data only advances behind a valid, so the output holds between responses
            for (int s = 1; s < RD_LAT; s++) begin
                vld_p_q[s] <= vld_p_q[s-1];
                err_p_q[s] <= err_p_q[s-1];
                if (vld_p_q[s-1]) data_p_q[s] <= data_p_q[s-1];
            end
        end
    end

    assign vld_o  = vld_p_q[RD_LAT-1];
    assign err_o  = err_p_q[RD_LAT-1];
    assign data_o = data_p_q[RD_LAT-1];

endmodule

// File: rtl/data_memory_pipe.sv
// MEM-stage data memory: byte-lane writes, pipelined reads, range check and post-reset clear sweep.
module data_memory_pipe
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  addr_err_o
);

    localparam int                IDX_W   = $clog2(DEPTH);
    localparam int                LANES   = lanes(DATA_W);
    localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [LANES-1:0]  be);
        merge_lanes = old_w;
        for (int i = 0; i < LANES; i++)
            if (be[i]) merge_lanes[8*i +: 8] = new_w[8*i +: 8];
    endfunction

    state_e            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              ready_q;
    logic              wr_err_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              rd_vld_d;
    logic [DATA_W-1:0] rd_word_d;
    logic              pipe_err;

    // Range check uses the full address; the index slice is only trusted when in range
    assign accept    = req_valid_i & ready_q;
    assign in_range  = {1'b0, addr_i} < DEPTH_X;
    assign idx       = addr_i[IDX_W-1:0];
    assign rd_vld_d  = accept & ~req_we_i;
    assign rd_word_d = in_range ? mem_q[idx] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= accept & req_we_i & ~in_range;
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN:  ready_q <= 1'b1;
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR)
            mem_q[cnt_q] <= '0;
        else if (accept && req_we_i && in_range)
            mem_q[idx] <= merge_lanes(mem_q[idx], wdata_i, be_i);
    end

    dm_read_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_read_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .vld_i  (rd_vld_d),
        .data_i (rd_word_d),
        .err_i  (~in_range),
        .vld_o  (rsp_valid_o),
        .data_o (rdata_o),
        .err_o  (pipe_err)
    );

    assign req_ready_o = ready_q;
    assign addr_err_o  = pipe_err | wr_err_q;

endmodule

// File: tb/tb_data_memory_pipe.sv
// Directed bench driving a 1-cycle and a 2-cycle read-latency memory with identical requests.
module tb_data_memory_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [15:0] addr, wdata;
    logic [1:0]  be;
    logic        ready1, rv1, err1, ready2, rv2, err2;
    logic [15:0] rd1, rd2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_memory_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(32), .RD_LAT(1)) u_l1 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready1),
        .req_we_i(req_we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .rsp_valid_o(rv1), .rdata_o(rd1), .addr_err_o(err1));

    data_memory_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(32), .RD_LAT(2)) u_l2 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready2),
        .req_we_i(req_we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
        .rsp_valid_o(rv2), .rdata_o(rd2), .addr_err_o(err2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds a write request through the sweep; it must be ignored until ready rises.
    task automatic wait_sweep(input string tag);
        int n1 = 0;
        int n2 = 0;
        logic saw_rv = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; addr = 16'd5; wdata = 16'hFFFF; be = 2'b11;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (rv1 || rv2) saw_rv = 1'b1;
            if (ready1 && n1 == 0) n1 = i;
            if (ready2 && n2 == 0) n2 = i;
            if (n1 != 0 && n2 != 0) break;
        end
        req_valid = 1'b0;
        chk({tag, "_sweep_l1"}, n1, 32);
        chk({tag, "_sweep_l2"}, n2, 32);
        chk({tag, "_sweep_no_rsp"}, saw_rv, 0);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] b,
                            input logic exp_err);
        req_valid = 1'b1; req_we = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk($sformatf("wr%0d_rv", a), {rv1, rv2}, 0);
        chk($sformatf("wr%0d_err", a), {err1, err2}, {exp_err, exp_err});
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input logic exp_err);
        req_valid = 1'b1; req_we = 1'b0; addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk($sformatf("rd%0d_l1_rv", a), rv1, 1);
        chk($sformatf("rd%0d_l1_data", a), rd1, exp);
        chk($sformatf("rd%0d_l1_err", a), err1, exp_err);
        chk($sformatf("rd%0d_l2_early", a), rv2, 0);
        @(posedge clk); #1;
        chk($sformatf("rd%0d_l2_rv", a), rv2, 1);
        chk($sformatf("rd%0d_l2_data", a), rd2, exp);
        chk($sformatf("rd%0d_l2_err", a), err2, exp_err);
        chk($sformatf("rd%0d_l1_off", a), {rv1, err1}, 0);
        chk($sformatf("rd%0d_l1_hold", a), rd1, exp);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; addr = '0; wdata = '0; be = '0;

        // Reset state, then the clear sweep and an all-zero array
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {ready1, ready2}, 0);
        chk("rst_rv", {rv1, rv2}, 0);
        chk("rst_rdata", {rd1, rd2}, 0);
        chk("rst_err", {err1, err2}, 0);
        rst_n = 1'b1;
        wait_sweep("init");
        for (int a = 0; a < 32; a++) do_read(16'(a), 16'h0000, 1'b0);

        // Full write then read on the very next cycle
        do_write(16'd5, 16'hBEEF, 2'b11, 1'b0);
        do_read(16'd5, 16'hBEEF, 1'b0);

        // Byte lanes
        do_write(16'd7, 16'h1234, 2'b11, 1'b0);
        do_write(16'd7, 16'hABCD, 2'b10, 1'b0);
        do_read(16'd7, 16'hAB34, 1'b0);
        do_write(16'd7, 16'hFFFF, 2'b00, 1'b0);
        do_read(16'd7, 16'hAB34, 1'b0);
        do_write(16'd5, 16'h0055, 2'b01, 1'b0);
        do_read(16'd5, 16'hBE55, 1'b0);

        // Out-of-range accesses, no aliasing onto low words
        do_read(16'd32, 16'h0000, 1'b1);
        do_read(16'hFFFF, 16'h0000, 1'b1);
        do_write(16'd40, 16'hDEAD, 2'b11, 1'b1);
        @(posedge clk); #1;
        chk("wr40_err_gone", {err1, err2}, 0);
        do_read(16'd8, 16'h0000, 1'b0);
        do_read(16'd5, 16'hBE55, 1'b0);

        // Back-to-back reads 1,2,3
        do_write(16'd1, 16'h1111, 2'b11, 1'b0);
        do_write(16'd2, 16'h2222, 2'b11, 1'b0);
        do_write(16'd3, 16'h3333, 2'b11, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; addr = 16'd1;
        @(posedge clk); #1;
        addr = 16'd2;
        chk("b2b_e0_l1", {rv1, rd1}, {1'b1, 16'h1111});
        chk("b2b_e0_l2", rv2, 0);
        @(posedge clk); #1;
        addr = 16'd3;
        chk("b2b_e1_l1", {rv1, rd1}, {1'b1, 16'h2222});
        chk("b2b_e1_l2", {rv2, rd2}, {1'b1, 16'h1111});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_e2_l1", {rv1, rd1}, {1'b1, 16'h3333});
        chk("b2b_e2_l2", {rv2, rd2}, {1'b1, 16'h2222});
        @(posedge clk); #1;
        chk("b2b_e3_l1", rv1, 0);
        chk("b2b_e3_l2", {rv2, rd2}, {1'b1, 16'h3333});
        @(posedge clk); #1;
        chk("b2b_e4_l2", rv2, 0);

        // Write behind an in-flight read leaves that read's data alone
        req_valid = 1'b1; req_we = 1'b0; addr = 16'd1;
        @(posedge clk); #1;
        req_we = 1'b1; wdata = 16'hFFFF; be = 2'b11;
        chk("haz_l1", {rv1, rd1}, {1'b1, 16'h1111});
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("haz_l2_old", {rv2, rd2}, {1'b1, 16'h1111});
        do_read(16'd1, 16'hFFFF, 1'b0);

        // Reset with a read in flight
        req_valid = 1'b1; req_we = 1'b0; addr = 16'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrd_rv", {rv1, rv2}, 0);
        chk("midrd_rdata", {rd1, rd2}, 0);
        chk("midrd_ready", {ready1, ready2}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrd_rv_hold", {rv1, rv2}, 0);
        rst_n = 1'b1;
        wait_sweep("midrd");

        // Reset ten cycles into the sweep; the sweep starts over
        do_write(16'd9, 16'h5A5A, 2'b11, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midsw_ready", {ready1, ready2}, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_sweep("midsw");
        do_read(16'd5, 16'h0000, 1'b0);
        do_read(16'd9, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
